// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial sequence detector with a runtime-loadable pattern
module seq_detect_param #(
  parameter int N = 4,
  parameter logic [N-1:0] PATTERN = 4'b1101,
  parameter int OVERLAP = 1,
  parameter int CW = 8,
  localparam int LW = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          x,
  input  logic          load,
  input  logic [N-1:0]  pat_in,
  output logic          out,
  output logic          det_r,
  output logic [CW-1:0] det_cnt,
  output logic [LW-1:0] match_len
);
  logic [N-1:0] pat_q, pat_d, win;
  logic [N-2:0] hist_q, hist_d;
  logic [LW-1:0] vcnt_q, vcnt_d, ml;
  logic [CW-1:0] cnt_q, cnt_d;
  logic det_q, acc, full, m;
  // Mealy match: history plus the incoming bit compared against the active pattern
  always_comb begin
    acc = en & ~load & ~rst;
    win = {hist_q, x};
    full = vcnt_q == LW'(N-1);
    m = acc & full & (win == pat_q);
  end
  // next state: load beats an accepted bit; non-overlap restarts history depth on a match
  always_comb begin
    pat_d = load ? pat_in : pat_q;
    hist_d = acc ? win[N-2:0] : hist_q;
    vcnt_d = (load | (m & (OVERLAP == 0))) ? '0 : (acc & ~full) ? vcnt_q + 1'b1 : vcnt_q;
    cnt_d = (m & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  // longest pattern prefix that ends the history, capped by the valid history depth
  always_comb begin
    ml = '0;
    for (int k = 1; k < N; k++)
      if (k <= int'(vcnt_q) && (({1'b0, hist_q} & ((N'(1) << k) - 1'b1)) == (pat_q >> (N - k))))
        ml = LW'(k);
  end
  // state registers with synchronous reset taking priority over load and enable
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= PATTERN;
      hist_q <= '0;
      vcnt_q <= '0;
      det_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pat_q <= pat_d;
      hist_q <= hist_d;
      vcnt_q <= vcnt_d;
      det_q <= m;
      cnt_q <= cnt_d;
    end
  end
  assign out = m;
  assign det_r = det_q;
  assign det_cnt = cnt_q;
  assign match_len = ml;
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: scoreboard bench over overlap, non-overlap and narrow-counter instances
module tb_seq_detect_param;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, x = 1'b0, load = 1'b0;
  logic [3:0] pat_in = '0;
  logic [2:0] out_v, dr_v;
  logic [2:0][2:0] ml_v;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  int nchk = 0, nerr = 0;
  typedef struct packed {
    logic [2:0] d;
    logic [2:0][7:0] c;
    logic [2:0][2:0] ml;
  } exp_t;
  exp_t q[$];
  logic [3:0] mpat = 4'b1101;
  logic [2:0] mh = '0;
  int mvc[3], mcnt[3];
  int ovl[3] = '{1, 0, 1};
  int cmax[3] = '{255, 255, 3};
  always #5 clk = ~clk;
  seq_detect_param #(.OVERLAP(1)) u0 (.clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .out(out_v[0]), .det_r(dr_v[0]), .det_cnt(c0), .match_len(ml_v[0]));
  seq_detect_param #(.OVERLAP(0)) u1 (.clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .out(out_v[1]), .det_r(dr_v[1]), .det_cnt(c1), .match_len(ml_v[1]));
  seq_detect_param #(.OVERLAP(1), .CW(2)) u2 (.clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .out(out_v[2]), .det_r(dr_v[2]), .det_cnt(c2), .match_len(ml_v[2]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  function automatic int prefix_len(input int vc);
    int best = 0;
    for (int k = 1; k <= vc; k++) begin
      bit ok = 1'b1;
      for (int j = 0; j < k; j++)
        if (mh[k-1-j] != mpat[3-j]) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction
  task automatic step(input logic r, input logic e, input logic b, input logic l, input logic [3:0] p);
    exp_t ex, got;
    logic acc;
    logic [2:0] m;
    rst = r; en = e; x = b; load = l; pat_in = p;
    #1;
    acc = e & ~l & ~r;
    for (int i = 0; i < 3; i++) begin
      m[i] = acc && mvc[i] == 3 && {mh, b} == mpat;
      chk($sformatf("out%0d", i), {31'b0, out_v[i]}, {31'b0, m[i]});
    end
    if (r) begin
      mpat = 4'b1101; mh = '0;
      for (int i = 0; i < 3; i++) begin mvc[i] = 0; mcnt[i] = 0; end
    end else if (l) begin
      mpat = p;
      for (int i = 0; i < 3; i++) mvc[i] = 0;
    end else if (e) begin
      mh = {mh[1:0], b};
      for (int i = 0; i < 3; i++) begin
        mvc[i] = (m[i] && ovl[i] == 0) ? 0 : (mvc[i] < 3 ? mvc[i] + 1 : 3);
        if (m[i] && mcnt[i] < cmax[i]) mcnt[i]++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      ex.d[i] = m[i];
      ex.c[i] = 8'(mcnt[i]);
      ex.ml[i] = 3'(prefix_len(mvc[i]));
    end
    q.push_back(ex);
    @(posedge clk);
    #1;
    ex = q.pop_front();
    got.d = dr_v;
    got.c = {{6'b0, c2}, c1, c0};
    got.ml = ml_v;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("det_r%0d", i), {31'b0, got.d[i]}, {31'b0, ex.d[i]});
      chk($sformatf("det_cnt%0d", i), {24'b0, got.c[i]}, {24'b0, ex.c[i]});
      chk($sformatf("match_len%0d", i), {29'b0, got.ml[i]}, {29'b0, ex.ml[i]});
    end
  endtask
  task automatic bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(0, 1, v[i], 0, 4'b0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin mvc[i] = 0; mcnt[i] = 0; end
    @(posedge clk); #1;
    step(1, 1, 1, 0, 4'b0);
    step(1, 1, 1, 0, 4'b0);
    chk("rst_cnt", {24'b0, c0}, 32'd0);
    chk("rst_len", {29'b0, ml_v[0]}, 32'd0);
    bits(16'b1101, 4);
    chk("ov_len_after4", {29'b0, ml_v[0]}, 32'd1);
    bits(16'b101, 3);
    chk("ov_cnt", {24'b0, c0}, 32'd2);
    chk("nov_cnt", {24'b0, c1}, 32'd1);
    step(1, 0, 0, 0, 4'b0);
    for (int b = 3; b >= 0; b--) begin
      logic [3:0] s = 4'b1101;
      for (int g = 0; g < 3; g++) step(0, 0, 1'($urandom_range(1)), 0, 4'b0);
      step(0, 1, s[b], 0, 4'b0);
    end
    chk("gap_cnt", {24'b0, c0}, 32'd1);
    step(1, 0, 0, 0, 4'b0);
    bits(16'b110, 3);
    step(0, 1, 1, 1, 4'b0110);
    bits(16'b1011, 4);
    chk("load_no_early", {24'b0, c0}, 32'd0);
    step(0, 1, 0, 0, 4'b0);
    chk("load_hit_pulse", {31'b0, dr_v[0]}, 32'd1);
    step(1, 1, 1, 1, 4'b0110);
    bits(16'b1101, 4);
    chk("rst_over_load", {24'b0, c0}, 32'd1);
    step(1, 0, 0, 0, 4'b0);
    bits(16'b1101, 4);
    for (int r = 0; r < 5; r++) bits(16'b101, 3);
    chk("sat_cnt", {30'b0, c2}, 32'd3);
    chk("wide_cnt", {24'b0, c0}, 32'd6);
    bits(16'b110, 3);
    step(1, 1, 1, 0, 4'b0);
    step(0, 1, 1, 0, 4'b0);
    chk("midrst_out", {31'b0, dr_v[2]}, 32'd0);
    chk("midrst_cnt", {30'b0, c2}, 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
